food_placer: RTL
================

# food_placer

Controller that sequences the free-running grid point generator to place a new food item on the 800x600, 20-pixel playfield. On a placement request it samples the generator's current (X,Y) point and validates range and grid alignment. It then queries the snake-body occupancy logic through a request/acknowledge handshake and retries on collision until a free cell is found or a try budget runs out. It sits between the point generator, the snake body store and the game-state FSM.

## Interface
- GRID, 20, cell pitch in pixels
- X_MIN, 20, lowest legal X
- X_MAX, 780, highest legal X
- Y_MIN, 20, lowest legal Y
- Y_MAX, 580, highest legal Y
- MAX_TRIES, 16, rejected candidates allowed before failure (>=1)
- INIT_X, 400, foodX reset value
- INIT_Y, 300, foodY reset value

Ports:
- CLK_100MHz  in  1  system clock; one clock domain, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- randX  in  11  current generator X, changes every cycle
- randY  in  11  current generator Y, changes every cycle
- place_req  in  1  placement request, sampled only in IDLE
- occ_query  out  1  occupancy query valid
- occ_x  out  11  candidate X under query
- occ_y  out  11  candidate Y under query
- occ_ack  in  1  occupancy answer valid, honoured only while occ_query=1
- occ_hit  in  1  1 = candidate cell occupied by snake, valid with occ_ack
- foodX  out  11  committed food X
- foodY  out  11  committed food Y
- food_valid  out  1  committed position is current
- busy  out  1  high in every state except IDLE
- place_fail  out  1  one-cycle pulse, try budget exhausted

## Operation
- States: IDLE, SAMPLE, QUERY.
- IDLE: busy=0. Behaviour on place_req=1:
  - go to SAMPLE
  - clear food_valid
  - clear try counter
- SAMPLE: latch randX/randY into candidate registers cand_x/cand_y. The candidate is accepted when all of the following hold; accepted goes to QUERY:
  - X_MIN<=randX<=X_MAX
  - Y_MIN<=randY<=Y_MAX
  - randX%GRID==0
  - randY%GRID==0
- SAMPLE, candidate fails any check: the candidate is rejected.
- QUERY: occ_query=1, with occ_x=cand_x and occ_y=cand_y held stable until ack.
  - occ_ack=1 with occ_hit=0: foodX<=cand_x, foodY<=cand_y, food_valid<=1, go to IDLE.
  - occ_ack=1 with occ_hit=1: the candidate is rejected.
  - No ack: stay in QUERY indefinitely (no timeout).
- Rejection, from either state: try counter increments.
  - New count == MAX_TRIES: place_fail=1 for one cycle, go to IDLE. food_valid stays 0; foodX/foodY keep their previous values.
  - Otherwise: go to SAMPLE.
- Try counter width: $clog2(MAX_TRIES+1); it never wraps.
- place_req while busy=1 is ignored, with no queuing.
- place_req in IDLE while food_valid=1 starts a new placement and drops food_valid.
- occ_ack while occ_query=0 is ignored.
- Range comparisons are unsigned 11-bit.

## Timing
- Reset values: state=IDLE, occ_query=0, occ_x=0, occ_y=0, foodX=INIT_X, foodY=INIT_Y, food_valid=0, busy=0, place_fail=0, try counter=0.
- RST mid-operation aborts the placement:
  - all outputs take their reset values on that edge
  - occ_query drops the same edge
  - no place_fail is emitted
- Outputs are registered; nothing depends combinationally on inputs.
- Minimum latency:
  - place_req high at edge N.
  - N+1: SAMPLE, busy=1, food_valid=0.
  - N+2: QUERY, occ_query=1.
  - ack with no hit in cycle N+2: food_valid=1 and new foodX/foodY at edge N+3; busy=0 at N+3.
- Each collision costs 2 cycles plus ack wait. Each range/alignment reject costs 1 cycle.
- place_fail asserts the cycle after the final rejection, coincident with the return to IDLE.

## Test plan
- Reset with randX=0, randY=0 -> foodX=400, foodY=300, food_valid=0, busy=0, occ_query=0.
- place_req pulse, randX=100, randY=200 at the SAMPLE edge, occ_ack=1 and occ_hit=0 same cycle as occ_query -> occ_x=100, occ_y=200; foodX=100, foodY=200, food_valid=1 exactly 3 cycles after the request edge.
- Collision retry: first query answered occ_hit=1 (cand 40,40), second query occ_hit=0 (cand 60,60) -> food at (60,60). occ_query drops for exactly the one SAMPLE cycle between the two queries.
- Budget exhaustion with MAX_TRIES=4, every query occ_hit=1 -> exactly 4 queries, then place_fail high one cycle. food_valid=0; foodX/foodY unchanged from the prior placement.
- Out-of-range/misaligned source: randX=790 then randX=105 then randX=120, with randY=20 -> the first two are rejected without raising occ_query, the third is queried. Try counter reads 2 before the query.
- Ack stall plus RST: hold occ_ack=0 for 50 cycles -> occ_query and occ_x/occ_y stay stable. Assert RST -> next edge shows all reset values; a subsequent place_req works normally.

Source files
------------

// File: rtl/food_placer.sv
// food_placer: picks a free, grid-aligned cell for the next food item.
// It samples the free-running point generator and rejects off-field or
// misaligned points. It then asks the snake body store whether the cell is
// occupied, and retries until the cell is free or the try budget is used up.
module food_placer #(
  parameter int GRID      = 20,
  parameter int X_MIN     = 20,
  parameter int X_MAX     = 780,
  parameter int Y_MIN     = 20,
  parameter int Y_MAX     = 580,
  parameter int MAX_TRIES = 16,
  parameter int INIT_X    = 400,
  parameter int INIT_Y    = 300
) (
  input  logic        CLK_100MHz,
  input  logic        RST,
  input  logic [10:0] randX,
  input  logic [10:0] randY,
  input  logic        place_req,
  output logic        occ_query,
  output logic [10:0] occ_x,
  output logic [10:0] occ_y,
  input  logic        occ_ack,
  input  logic        occ_hit,
  output logic [10:0] foodX,
  output logic [10:0] foodY,
  output logic        food_valid,
  output logic        busy,
  output logic        place_fail
);

  localparam int TryW = $clog2(MAX_TRIES + 1);

  localparam logic [10:0]     GridW    = 11'(GRID);
  localparam logic [10:0]     XMinW    = 11'(X_MIN);
  localparam logic [10:0]     XMaxW    = 11'(X_MAX);
  localparam logic [10:0]     YMinW    = 11'(Y_MIN);
  localparam logic [10:0]     YMaxW    = 11'(Y_MAX);
  localparam logic [10:0]     InitXW   = 11'(INIT_X);
  localparam logic [10:0]     InitYW   = 11'(INIT_Y);
  localparam logic [TryW-1:0] MaxTries = TryW'(MAX_TRIES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    QUERY  = 2'd2
  } stateT;

  stateT           state;
  logic [TryW-1:0] tryCount;
  logic [10:0]     candX;
  logic [10:0]     candY;

  logic            candOk;
  logic [TryW-1:0] tryNext;
  logic            tryLast;

  // Judge the generator's current point and work out what the next rejection would do to the budget.
  always_comb begin
    candOk  = (randX >= XMinW) && (randX <= XMaxW) &&
              (randY >= YMinW) && (randY <= YMaxW) &&
              ((randX % GridW) == 11'd0) && ((randY % GridW) == 11'd0);
    tryNext = tryCount + TryW'(1);
    tryLast = (tryNext == MaxTries);
  end

  // Placement sequencer. All outputs are registered here so that none of them follows the inputs combinationally.
  always_ff @(posedge CLK_100MHz) begin
    if (RST) begin
      state      <= IDLE;
      tryCount   <= '0;
      candX      <= '0;
      candY      <= '0;
      occ_query  <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      foodX      <= InitXW;
      foodY      <= InitYW;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      place_fail <= 1'b0;
    end else begin
      place_fail <= 1'b0;
      case (state)
        IDLE: begin
          if (place_req) begin
            state      <= SAMPLE;
            busy       <= 1'b1;
            food_valid <= 1'b0;
            tryCount   <= '0;
          end
        end
        SAMPLE: begin
          candX <= randX;
          candY <= randY;
          if (candOk) begin
            state     <= QUERY;
            occ_query <= 1'b1;
            occ_x     <= randX;
            occ_y     <= randY;
          end else begin
            tryCount <= tryNext;
            if (tryLast) begin
              state      <= IDLE;
              busy       <= 1'b0;
              place_fail <= 1'b1;
            end
          end
        end
        QUERY: begin
          if (occ_ack) begin
            occ_query <= 1'b0;
            if (!occ_hit) begin
              foodX      <= candX;
              foodY      <= candY;
              food_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              tryCount <= tryNext;
              if (tryLast) begin
                state      <= IDLE;
                busy       <= 1'b0;
                place_fail <= 1'b1;
              end else begin
                state <= SAMPLE;
              end
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          occ_query <= 1'b0;
        end
      endcase
    end
  end

endmodule
